// File: rtl/uart_console_pkg.sv
// Shared types and constants for the console UART receive path.
package uart_console_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;
    localparam int SAMPLE_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_console_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible whenever non-empty.
module uart_console_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_console_rx.sv
// 16x-oversampled 8N1 console receiver with stop-bit check, break detect and FWFT buffer.
module uart_console_rx
    import uart_console_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int FIFO_AW   = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    input  logic                 rx_i,
    output logic [7:0]           m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 overflow_o,
    output logic [FIFO_AW:0]     fifo_level_o
);

    localparam logic [SAMPLE_W-1:0] MID_CNT  = SAMPLE_W'(MID_SAMPLE);
    localparam logic [SAMPLE_W-1:0] LAST_CNT = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]    LAST_BIT = BIT_W'(DATA_BITS - 1);

    rx_state_e              state, next_state;
    logic                   rx_meta, rxs;
    logic [DIV_WIDTH-1:0]   tick_cnt, reload_val;
    logic                   tick;
    logic [SAMPLE_W-1:0]    sample_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   start_rx, clr_sample, shift_en, push, fe_set, brk_set;
    logic                   fifo_full, fifo_empty;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    assign reload_val = (divisor_i == '0) ? '0 : divisor_i - DIV_WIDTH'(1);
    assign tick       = (tick_cnt == '0);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        start_rx   = 1'b0;
        clr_sample = 1'b0;
        shift_en   = 1'b0;
        push       = 1'b0;
        fe_set     = 1'b0;
        brk_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    start_rx   = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (tick && sample_cnt == MID_CNT) begin
                    if (rxs) begin
                        next_state = IDLE;
                    end else begin
                        clr_sample = 1'b1;
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (tick && sample_cnt == LAST_CNT) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) next_state = STOP;
                end
            end
            STOP: begin
                if (tick && sample_cnt == LAST_CNT) begin
                    if (rxs) begin
                        push       = 1'b1;
                        next_state = IDLE;
                    end else begin
                        fe_set     = 1'b1;
                        brk_set    = (shift_reg == '0);
                        next_state = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held break must see the line idle before a new start is accepted.
                if (rxs) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= next_state;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tick_cnt    <= '0;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            frame_err_o <= 1'b0;
            break_o     <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            // Reload on start detection so ticks are phased to the falling edge.
            tick_cnt <= (start_rx || tick) ? reload_val : tick_cnt - DIV_WIDTH'(1);
            if (start_rx || clr_sample) sample_cnt <= '0;
            else if (tick)              sample_cnt <= sample_cnt + SAMPLE_W'(1);
            if (start_rx)      bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + BIT_W'(1);
            if (shift_en) shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            frame_err_o <= fe_set;
            break_o     <= brk_set;
            // When full the FIFO is non-empty, so a ready consumer frees a slot this cycle.
            overflow_o  <= push && fifo_full && !m_ready_i;
        end
    end

    uart_console_fifo #(
        .AW (FIFO_AW),
        .DW (DATA_BITS)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .push      (push),
        .push_data (shift_reg),
        .pop       (m_ready_i),
        .pop_data  (m_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level_o)
    );

    assign m_valid_o = !fifo_empty;

endmodule

// File: doc/uart_console_rx.md
Name: uart_console_rx

Overview:
- Serial receiver that consumes the uart16550 `stx_pad_o` line in simulation and FPGA console builds.
- Oversamples 16x, deframes 8N1 characters, checks the stop bit, detects breaks and buffers bytes in a first-word-fall-through FIFO.
- Output is a valid/ready byte stream for a console printer or a host bridge.
- Replaces the ad-hoc transceiver-plus-`$write` console path with a buffered, checked stage.

Parameters:
- DIV_WIDTH, 16, width of `divisor_i`.
- FIFO_AW, 4, log2 of FIFO depth (default depth 16).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- divisor_i  in  DIV_WIDTH  clocks per oversample tick; 0 treated as 1.
- rx_i  in  1  serial input, idle high, asynchronous to wb_clk_i.
- m_data_o  out  8  head-of-FIFO byte.
- m_valid_o  out  1  FIFO non-empty.
- m_ready_i  in  1  consumer pops head when m_valid_o & m_ready_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- break_o  out  1  one-cycle pulse: all-zero character with stop bit low.
- overflow_o  out  1  one-cycle pulse: good byte dropped because FIFO full.
- fifo_level_o  out  FIFO_AW+1  current occupancy, 0..2**FIFO_AW.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - All outputs 0 except m_data_o, which is don't-care but driven 0.
  - Synchroniser flops reset to 1; FSM in IDLE; tick counter 0; FIFO empty.
- Input sync: rx_i passes through 2 flops. All decisions use the synchronised value `rxs`.
- Tick generator:
  - Down-counter reloads with max(divisor_i,1)-1 and emits `tick` when it reaches 0.
  - Free-running; forced to reload when leaving IDLE so the start bit is phase-aligned.
- Sample counter: 4 bits, advances on `tick`; one bit period = 16 ticks.
- FSM states and transitions:
  - IDLE: `rxs`==0 -> START, clearing the sample counter and tick counter.
  - START: at sample 7 (mid start bit):
    - `rxs`==1 -> IDLE (false start, no flags).
    - otherwise clear the sample counter -> DATA.
  - DATA:
    - Every 16 ticks from the start mid-point, shift `rxs` in, LSB first.
    - After bit 7 -> STOP.
  - STOP: 16 ticks after bit 7, sample `rxs`:
    - 1: push byte -> IDLE.
    - 0: pulse frame_err_o, discard byte. If byte==0x00 also pulse break_o. -> WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1, then -> IDLE. This prevents a held break from retriggering.
- Latency: byte is visible on m_valid_o/m_data_o in the cycle after the stop-sample tick cycle.
- FIFO:
  - Depth 2**FIFO_AW; pointers FIFO_AW+1 bits; full when MSBs differ and low bits match.
  - m_data_o = mem[rd_ptr]; m_valid_o = !empty.
  - Push while full with no pop this cycle: byte dropped, overflow_o pulsed, contents unchanged.
  - Simultaneous push and pop when full: both occur, level unchanged, no overflow.
  - Simultaneous push and pop when empty: push only (nothing valid to pop).
  - Pointers wrap naturally modulo 2**(FIFO_AW+1).
- divisor_i is sampled at each counter reload. Changing it mid-character affects the remaining bits only; this is legal but unspecified for data integrity.
- Reset mid-character or mid-FIFO: everything clears immediately. Any partially received byte is lost, never pushed.

Decomposition:
- Shared package `uart_console_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - Constants OVERSAMPLE=16, MID_SAMPLE=7, DATA_BITS=8.
- One sub-module `uart_console_fifo`: sync FWFT FIFO with parameter AW and ports push/pop/full/empty/level. Reusable for the TX-side console later.

Test Plan:
- Single char: divisor_i=26, send 0x41 8N1 (bit period 416 clk), m_ready_i=1.
  -> m_valid_o high exactly 1 cycle after stop-sample tick, m_data_o=0x41, no flags.
- False start: divisor_i=26, 48-clock low glitch on rx_i.
  -> FSM back to IDLE, m_valid_o, frame_err_o and break_o stay 0.
- Frame error and break:
  - Send 0x55 with stop bit low -> single frame_err_o pulse, no push.
  - Hold rx_i low 20 bit times -> frame_err_o and break_o pulse once each; no restart until rx_i returns high.
- Overflow: FIFO_AW=4, m_ready_i=0, send 17 bytes 0x00..0x10 (valid stop bits).
  -> fifo_level_o=16, one overflow_o pulse on byte 0x10.
  -> then m_ready_i=1 drains 0x00..0x0F in order.
- Full push+pop: FIFO full, raise m_ready_i for exactly the cycle the 17th byte 0x7E is pushed.
  -> no overflow_o, level stays 16, 0x7E read last.
- Async reset mid-byte: assert wb_rst_ni low during DATA bit 4.
  -> all outputs 0 immediately.
  -> after release, next byte 0xA5 is received cleanly.
